pencoder_stream: RTL and testbench
==================================

# pencoder_stream

Sequential, parametrised successor to the combinational 32-to-5 priority encoder. It accepts one WIDTH-bit bitmask per transaction and emits the index of every set bit, one per cycle, MSB-first, over a valid/ready stream. It sits between the essential-bit mask generation and the bit-serial PE lanes. The indexing convention matches the existing encoder: bit WIDTH-1 maps to index 0 and bit 0 maps to index WIDTH-1.

## Interface
- WIDTH, 32: mask width; must be ≥2.
- MAX_BITS, WIDTH: maximum indices emitted per mask, range 1..WIDTH; remaining set bits are dropped.
- IDX_W, $clog2(WIDTH): localparam, index width.
- SEQ_W, $clog2(MAX_BITS+1): localparam, beat-counter width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  bitmask presented.
- in_ready  out  1  block can accept a mask this cycle.
- in_mask  in  WIDTH  bitmask to encode.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat.
- out_idx  out  IDX_W  index of current leading one (WIDTH-1-bitpos).
- out_val  out  1  1 = out_idx is real; 0 = input mask was all-zero.
- out_last  out  1  final beat of this mask.
- out_seq  out  SEQ_W  ordinal of beat within mask, 0-based.
- out_trunc  out  1  on last beat only: set bits were dropped because of MAX_BITS.

## Operation
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: out_valid=1.
- Accept: in_valid && in_ready loads mask_reg←in_mask, seq←0, state→EMIT.
- In EMIT, out_idx = priority encode of mask_reg, MSB-first, combinational from registers.
- out_val = |mask_reg.
- out_last = (popcount(mask_reg) ≤ 1) || (seq == MAX_BITS-1).
- out_trunc = out_last && (seq == MAX_BITS-1) && (popcount(mask_reg) > 1).
- Beat handshake (out_valid && out_ready), not last: clear the leading set bit of mask_reg and increment seq.
- Beat handshake, last: state→IDLE, unless a new mask is accepted in the same cycle.
- Back-to-back: in_ready = IDLE || (EMIT && out_ready && out_last). A mask accepted on the last-beat handshake loads directly and stays in EMIT with no bubble.
- All-zero mask: exactly one beat with out_val=0, out_idx=0, out_last=1, out_seq=0, out_trunc=0.
- in_mask is sampled only on accept; later changes to in_mask are ignored.
- Backpressure: while out_valid && !out_ready, all out_* hold stable.

## Timing
- Latency: the first beat is valid the cycle after accept.
- Throughput: one index per cycle with out_ready held high. A mask with k set bits occupies min(k, MAX_BITS) cycles; an empty mask occupies 1 cycle.
- Reset:
  - state=IDLE, mask_reg=0, seq=0.
  - out_valid=0; out_idx, out_val, out_last, out_seq and out_trunc are all 0.
  - in_ready=0 while reset is high and 1 the cycle after it is released.
- Reset mid-stream discards the transaction; no further beats are emitted for it.
- in_valid while in EMIT and not on the last handshake: not accepted; the producer holds.
- seq never exceeds MAX_BITS-1, so there is no wrap.

## Structure
- Sub-module pencoder_param: combinational, WIDTH-parametrised MSB-first priority encoder with outputs idx and any.
  - Instantiated once on mask_reg.
  - Also provides the leading-one one-hot used for clearing (mask_reg & ~onehot).
- Shared package bitsim_pkg holds only the IDX_W/SEQ_W width helper functions.
- The state enum (IDLE, EMIT) is local to the module.
- popcount ≤1 is implemented as (mask_reg & (mask_reg-1)) == 0; no adder tree.

## Test plan
- WIDTH=32, mask 0x8000_0001, out_ready=1 -> two beats:
  - beat 0: idx 0, seq 0, last 0.
  - beat 1: idx 31, seq 1, last 1, trunc 0.
  - Then IDLE.
- Mask 0x0000_0000 -> single beat: val 0, idx 0, last 1, seq 0; in_ready=1 the next cycle.
- Mask 0x0F00_0000, out_ready low for 3 cycles after beat 0 appears -> beat 0 (idx 4) held stable for 3 cycles, then idx 5, 6, 7 with last on idx 7.
- MAX_BITS=2, mask 0x0000_0007 -> idx 29 (seq 0), then idx 30 (seq 1, last 1, trunc 1); idx 31 is never emitted.
- Back-to-back: mask 0x0000_0003 followed by mask 0x4000_0000, with in_valid held during the last beat -> idx 30, 31, 1 on consecutive cycles with no bubble.
- Reset asserted during beat 1 of mask 0xFFFF_FFFF -> out_valid=0 the next cycle; after release, a new mask 0x0000_0001 yields idx 31, last 1.

Source files
------------

// File: rtl/bitsim_pkg.sv
// bitsim_pkg: width helpers shared by the bit-serial mask/encoder blocks
package bitsim_pkg;
  function automatic int idx_w(input int w);
    return $clog2(w);
  endfunction
  function automatic int seq_w(input int m);
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/pencoder_stream_if.sv
// pencoder_stream_if: mask-in / index-out valid-ready stream bundle
interface pencoder_stream_if import bitsim_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int MAX_BITS = WIDTH
) ();
  localparam int IDX_W = idx_w(WIDTH);
  localparam int SEQ_W = seq_w(MAX_BITS);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_val;
  logic             out_last;
  logic [SEQ_W-1:0] out_seq;
  logic             out_trunc;
  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_idx, out_val, out_last, out_seq, out_trunc
  );
  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_idx, out_val, out_last, out_seq, out_trunc
  );
endinterface

// File: rtl/pencoder_param.sv
// pencoder_param: MSB-first priority encoder; bit WIDTH-1 maps to index 0
module pencoder_param import bitsim_pkg::*; #(
  parameter int WIDTH = 32,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] i_mask,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any,
  output logic [WIDTH-1:0] o_onehot
);
  assign o_any = |i_mask;
  // later (higher) bits overwrite earlier ones, so the MSB wins
  always_comb begin
    o_idx    = '0;
    o_onehot = '0;
    for (int i = 0; i < WIDTH; i++)
      if (i_mask[i]) begin
        o_idx       = IDX_W'(WIDTH - 1 - i);
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
      end
  end
endmodule

// File: rtl/pencoder_stream.sv
// pencoder_stream: emits the index of every set bit of a mask, MSB-first,
// one beat per cycle over a valid/ready stream
module pencoder_stream import bitsim_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int MAX_BITS = WIDTH
) (
  input logic              clk,
  input logic              reset,
  pencoder_stream_if.slave s
);
  localparam int IDX_W = idx_w(WIDTH);
  localparam int SEQ_W = seq_w(MAX_BITS);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_mask;
  logic [SEQ_W-1:0] r_seq;
  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] w_onehot;
  logic             w_any, w_single, w_cap, w_last, w_emit, w_beat, w_acc;
  pencoder_param #(.WIDTH(WIDTH)) u_pe (
    .i_mask  (r_mask),
    .o_idx   (w_idx),
    .o_any   (w_any),
    .o_onehot(w_onehot)
  );
  // popcount <= 1 without an adder tree
  assign w_single = (r_mask & (r_mask - WIDTH'(1))) == '0;
  assign w_cap    = r_seq == SEQ_W'(MAX_BITS - 1);
  assign w_emit   = r_state == EMIT;
  assign w_last   = w_single || w_cap;
  assign w_beat   = w_emit && s.out_ready;
  assign w_acc    = s.in_valid && s.in_ready;
  assign s.in_ready  = !reset && (!w_emit || (w_beat && w_last));
  assign s.out_valid = w_emit;
  assign s.out_idx   = w_idx;
  assign s.out_val   = w_any;
  assign s.out_last  = w_emit && w_last;
  assign s.out_seq   = r_seq;
  assign s.out_trunc = w_emit && w_cap && !w_single;
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_seq   <= '0;
    end else if (w_acc) begin
      r_state <= EMIT;
      r_mask  <= s.in_mask;
      r_seq   <= '0;
    end else if (w_beat) begin
      r_state <= w_last ? IDLE : EMIT;
      r_mask  <= w_last ? r_mask : r_mask & ~w_onehot;
      r_seq   <= w_last ? r_seq : r_seq + SEQ_W'(1);
    end
endmodule

// File: tb/tb_pencoder_stream.sv
// tb_pencoder_stream: random + directed masks against a set-bit-list model
module tb_pencoder_stream;
  typedef struct packed {
    logic       val;
    logic [4:0] idx;
    logic       last;
    logic [5:0] seq;
    logic       trunc;
  } beat_t;
  logic clk = 0;
  logic reset = 1;
  logic rst_seen = 0;
  logic rmode = 0;
  logic rdir = 1;
  logic rnd = 1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  beat_t exp_q[$];
  beat_t log_q[$];
  int    log_cyc[$];
  pencoder_stream_if #(.WIDTH(32), .MAX_BITS(32)) ia ();
  pencoder_stream_if #(.WIDTH(32), .MAX_BITS(2))  ib ();
  pencoder_stream #(.WIDTH(32), .MAX_BITS(32)) u_a (.clk(clk), .reset(reset), .s(ia));
  pencoder_stream #(.WIDTH(32), .MAX_BITS(2))  u_b (.clk(clk), .reset(reset), .s(ib));
  assign ia.out_ready = rmode ? rnd : rdir;
  assign ib.out_ready = 1'b1;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    rst_seen <= reset;
    cyc <= cyc + 1;
  end
  always @(posedge clk) begin
    #1 rnd = $urandom_range(0, 3) != 0;
  end
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask
  // Expected beats: list the set bits from MSB down, keep the first MAX
  function automatic int model(input logic [31:0] m, input int mx, output beat_t b[32]);
    int k = $countones(m);
    int n = (k < mx) ? k : mx;
    int j = 0;
    for (int i = 0; i < 32; i++) b[i] = '0;
    if (k == 0) begin
      b[0].last = 1'b1;
      return 1;
    end
    for (int p = 31; p >= 0; p--)
      if (m[p] && j < n) begin
        b[j].val   = 1'b1;
        b[j].idx   = 5'(31 - p);
        b[j].seq   = 6'(j);
        b[j].last  = j == n - 1;
        b[j].trunc = (j == n - 1) && (k > mx);
        j++;
      end
    return n;
  endfunction
  function automatic beat_t mk(input bit v, input int idx, input bit l, input int sq, input bit t);
    return {v, 5'(idx), l, 6'(sq), t};
  endfunction
  // Per-cycle compare of DUT A against the expected-beat queue
  always @(negedge clk) begin
    beat_t b[32];
    beat_t got;
    int n;
    got = {ia.out_val, ia.out_idx, ia.out_last, ia.out_seq, ia.out_trunc};
    if (reset) begin
      if (rst_seen)
        check("reset_state", 64'({ia.in_ready, ia.out_valid, got}), 64'(0));
      exp_q.delete();
    end else begin
      check("in_ready", 64'(ia.in_ready),
            64'(exp_q.size() == 0 || (exp_q.size() == 1 && ia.out_ready)));
      check("out_valid", 64'(ia.out_valid), 64'(exp_q.size() != 0));
      if (ia.out_valid && exp_q.size() != 0) begin
        check("beat", 64'(got), 64'(exp_q[0]));
        if (ia.out_ready) begin
          log_q.push_back(got);
          log_cyc.push_back(cyc);
          void'(exp_q.pop_front());
        end
      end
      if (ia.in_valid && ia.in_ready) begin
        n = model(ia.in_mask, 32, b);
        for (int j = 0; j < n; j++) exp_q.push_back(b[j]);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_a(input logic [31:0] m);
    int t = 0;
    ia.in_valid = 1'b1;
    ia.in_mask  = m;
    @(negedge clk);
    while (!ia.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout_a: mask %h not accepted", m);
    end
    @(posedge clk);
    #1;
    ia.in_valid = 1'b0;
    ia.in_mask  = $urandom;
  endtask
  task automatic chk_log(input string nm, input int i, input beat_t e);
    check(nm, (i < log_q.size()) ? 64'(log_q[i]) : 64'(-1), 64'(e));
  endtask
  task automatic run_b(input logic [31:0] m);
    beat_t b[32];
    int n;
    int t = 0;
    n = model(m, 2, b);
    ib.in_valid = 1'b1;
    ib.in_mask  = m;
    @(negedge clk);
    while (!ib.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout_b: mask %h not accepted", m);
    end
    @(posedge clk);
    #1;
    ib.in_valid = 1'b0;
    ib.in_mask  = $urandom;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      check("b_beat", 64'({ib.out_valid, ib.out_val, ib.out_idx, ib.out_last, 4'b0, ib.out_seq, ib.out_trunc}),
            64'({1'b1, b[j]}));
    end
    @(negedge clk);
    check("b_idle", 64'(ib.out_valid), 64'(0));
    @(posedge clk);
    #1;
  endtask
  initial begin
    beat_t mb[32];
    int n;
    logic [31:0] m;
    ia.in_valid = 0;
    ia.in_mask  = '0;
    ib.in_valid = 0;
    ib.in_mask  = '0;
    // Pin the model against hand-derived beats
    n = model(32'h0000_0007, 2, mb);
    check("model_trunc_n", 64'(n), 64'(2));
    check("model_trunc_b1", 64'(mb[1]), 64'(mk(1, 30, 1, 1, 1)));
    n = model(32'h0000_0000, 32, mb);
    check("model_zero", 64'(mb[0]), 64'(mk(0, 0, 1, 0, 0)));
    tick(3);
    reset = 0;
    tick(1);
    log_q.delete(); log_cyc.delete();
    send_a(32'h8000_0001);
    tick(4);
    check("two_n", 64'(log_q.size()), 64'(2));
    chk_log("two_b0", 0, mk(1, 0, 0, 0, 0));
    chk_log("two_b1", 1, mk(1, 31, 1, 1, 0));
    log_q.delete(); log_cyc.delete();
    send_a(32'h0000_0000);
    tick(3);
    check("zero_n", 64'(log_q.size()), 64'(1));
    chk_log("zero_b0", 0, mk(0, 0, 1, 0, 0));
    log_q.delete(); log_cyc.delete();
    send_a(32'h0F00_0000);
    rdir = 0;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold", 64'({ia.out_valid, ia.out_idx, ia.out_seq}), 64'({1'b1, 5'd4, 6'd0}));
    end
    @(posedge clk);
    #1 rdir = 1;
    tick(6);
    check("bp_n", 64'(log_q.size()), 64'(4));
    chk_log("bp_b0", 0, mk(1, 4, 0, 0, 0));
    chk_log("bp_b1", 1, mk(1, 5, 0, 1, 0));
    chk_log("bp_b2", 2, mk(1, 6, 0, 2, 0));
    chk_log("bp_b3", 3, mk(1, 7, 1, 3, 0));
    log_q.delete(); log_cyc.delete();
    send_a(32'h0000_0003);
    send_a(32'h4000_0000);
    tick(4);
    chk_log("b2b_b0", 0, mk(1, 30, 0, 0, 0));
    chk_log("b2b_b1", 1, mk(1, 31, 1, 1, 0));
    chk_log("b2b_b2", 2, mk(1, 1, 1, 0, 0));
    check("b2b_gap", 64'(log_cyc.size() == 3 ? log_cyc[2] - log_cyc[0] : -1), 64'(2));
    send_a(32'hFFFF_FFFF);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_mid_valid", 64'(ia.out_valid), 64'(0));
    tick(1);
    log_q.delete(); log_cyc.delete();
    send_a(32'h0000_0001);
    tick(3);
    check("after_rst_n", 64'(log_q.size()), 64'(1));
    chk_log("after_rst_b0", 0, mk(1, 31, 1, 0, 0));
    rmode = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: m = $urandom;
        1: m = $urandom & $urandom & $urandom;
        2: m = '0;
        3: m = 32'd1 << $urandom_range(0, 31);
        default: m = ~($urandom & $urandom);
      endcase
      send_a(m);
      tick($urandom_range(0, 2));
    end
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'(0));
    rmode = 0;
    tick(1);
    run_b(32'h0000_0007);
    run_b(32'h0000_0000);
    run_b(32'h0000_0001);
    run_b(32'h8000_0001);
    for (int i = 0; i < 20; i++) run_b($urandom & $urandom);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
